// File: rtl/sm83_alu_pkg.sv
// sm83_alu_pkg: shared types and constants for the nibble-serial SM83 ALU sequencer.
package sm83_alu_pkg;
    localparam int ALU_WIDTH = 4;
    localparam int BCD_MAX = 9;
    localparam int BCD_ADJ = 6;
    typedef logic [ALU_WIDTH-1:0] hword_t;
    typedef enum logic [1:0] {OP_SHIFT, OP_DAA, OP_COND, OP_SWAP} alu_seq_op_t;
    typedef enum logic [2:0] {SH_RLC, SH_RRC, SH_RL, SH_RR, SH_SLA, SH_SRA, SH_SLL, SH_SRL} shift_mode_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/sm83_alu_digit.sv
// sm83_alu_digit: one digit step of a shift or BCD adjust, purely combinational.
module sm83_alu_digit #(
    parameter int W = 4
) (
    input  logic         daa,
    input  logic         right,
    input  logic         sub,
    input  logic         fix,
    input  logic         cin,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         cout,
    output logic         adj
);
    import sm83_alu_pkg::*;
    logic [W:0] v;
    logic       gt;
    always_comb begin
        v = {1'b0, d} + {{W{1'b0}}, cin};
        gt = int'(v) > BCD_MAX;
        adj = sub ? fix : (gt | fix);
        q = daa ? (sub ? (fix ? d - W'(BCD_ADJ) : d) : (adj ? v[W-1:0] + W'(BCD_ADJ) : v[W-1:0]))
                : (right ? {cin, d[W-1:1]} : {d[W-2:0], cin});
        cout = daa ? (~sub & gt) : (right ? d[0] : d[W-1]);
    end
endmodule

// File: rtl/sm83_alu_seq.sv
// sm83_alu_seq: digit-serial shift/DAA/condition sequencer for the SM83 4-bit ALU.
// Define SM83_ALU_SEQ_SWAP_EN to make op=3 a digit rotate instead of a NOP.
module sm83_alu_seq #(
    parameter int ALU_WIDTH = 4,
    parameter int DIGITS = 2,
    localparam int WORD_SIZE = ALU_WIDTH * DIGITS
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [2:0]           op543,
    input  logic                 sub,
    input  logic                 carry_in,
    input  logic                 half_in,
    input  logic                 zero_in,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 carry_out,
    output logic                 zero_out,
    output logic                 half_out,
    output logic                 cond_result
);
    import sm83_alu_pkg::*;
`ifdef SM83_ALU_SEQ_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif
    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    state_t               state_q, state_d;
    alu_seq_op_t          op_q, op_d;
    logic                 r_q, r_d, sub_q, sub_d, cin_q, cin_d, hin_q, hin_d, c_q, c_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [WORD_SIZE-1:0] opnd_q, opnd_d, res_q, res_d, dout_q, dout_d;
    logic                 cout_q, cout_d, zout_q, zout_d, hout_q, hout_d, cond_q, cond_d;
    logic [IW-1:0]        pos, npos;
    logic [ALU_WIDTH-1:0] dig, nxt, dq;
    logic                 fix, dcout, dadj, shc, run_op;

    // Right shifts walk MSB digit first; everything else walks LSB first.
    always_comb begin
        pos = r_q ? LAST - idx_q : idx_q;
        npos = (pos == LAST) ? '0 : pos + 1'b1;
        dig = opnd_q[int'(pos)*ALU_WIDTH +: ALU_WIDTH];
        nxt = opnd_q[int'(npos)*ALU_WIDTH +: ALU_WIDTH];
        fix = ((pos == '0) & hin_q) | ((pos == LAST) & cin_q);
        shc = (op543 == SH_RRC) ? data_in[0]
            : (op543 == SH_RLC || op543 == SH_SRA) ? data_in[WORD_SIZE-1]
            : (op543 == SH_RL || op543 == SH_RR) ? carry_in
            : (op543 == SH_SLL);
        run_op = (op == OP_SHIFT) | (op == OP_DAA) | ((op == OP_SWAP) & SWAP_EN);
    end

    sm83_alu_digit #(.W(ALU_WIDTH)) u_digit (
        .daa(op_q == OP_DAA), .right(r_q), .sub(sub_q), .fix(fix), .cin(c_q),
        .d(dig), .q(dq), .cout(dcout), .adj(dadj)
    );

    always_comb begin
        state_d = state_q;
        op_d = op_q;
        r_d = r_q;
        sub_d = sub_q;
        cin_d = cin_q;
        hin_d = hin_q;
        c_d = c_q;
        idx_d = idx_q;
        opnd_d = opnd_q;
        res_d = res_q;
        dout_d = dout_q;
        cout_d = cout_q;
        zout_d = zout_q;
        hout_d = hout_q;
        cond_d = cond_q;
        case (state_q)
            ST_IDLE: if (start) begin
                op_d = alu_seq_op_t'(op);
                r_d = (op == OP_SHIFT) & op543[0];
                sub_d = sub;
                cin_d = carry_in;
                hin_d = half_in;
                c_d = (op == OP_SHIFT) & shc;
                idx_d = '0;
                opnd_d = data_in;
                state_d = run_op ? ST_RUN : ST_DONE;
                if (op == OP_COND) begin
                    cond_d = op543[1] ? (carry_in ^ ~op543[0]) : (zero_in ^ ~op543[0]);
                    zout_d = zero_in;
                    hout_d = half_in;
                end else if (!run_op) begin
                    dout_d = data_in;
                    zout_d = (data_in == '0);
                    cout_d = carry_in;
                    hout_d = 1'b0;
                end
            end
            ST_RUN: begin
                res_d[int'(pos)*ALU_WIDTH +: ALU_WIDTH] = (op_q == OP_SWAP) ? nxt : dq;
                c_d = dcout;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = ST_DONE;
                    idx_d = '0;
                    dout_d = res_d;
                    zout_d = (res_d == '0);
                    hout_d = 1'b0;
                    cout_d = (op_q == OP_SHIFT) ? dcout : (op_q == OP_DAA) ? (sub_q ? cin_q : dadj) : 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            op_q <= OP_SHIFT;
            r_q <= 1'b0;
            sub_q <= 1'b0;
            cin_q <= 1'b0;
            hin_q <= 1'b0;
            c_q <= 1'b0;
            idx_q <= '0;
            opnd_q <= '0;
            res_q <= '0;
            dout_q <= '0;
            cout_q <= 1'b0;
            zout_q <= 1'b0;
            hout_q <= 1'b0;
            cond_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            r_q <= r_d;
            sub_q <= sub_d;
            cin_q <= cin_d;
            hin_q <= hin_d;
            c_q <= c_d;
            idx_q <= idx_d;
            opnd_q <= opnd_d;
            res_q <= res_d;
            dout_q <= dout_d;
            cout_q <= cout_d;
            zout_q <= zout_d;
            hout_q <= hout_d;
            cond_q <= cond_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign data_out = dout_q;
    assign carry_out = cout_q;
    assign zero_out = zout_q;
    assign half_out = hout_q;
    assign cond_result = cond_q;
endmodule

// File: doc/sm83_alu_seq.md
Name: sm83_alu_seq

Overview:
Nibble-serial ALU control sequencer, the parametrised successor of the single-byte shift/DAA/condition control logic. Processes a WORD_SIZE-wide operand one ALU_WIDTH digit per cycle. Handles the eight SM83 shift/rotate modes, multi-digit BCD adjust (add and subtract) and flag-condition evaluation. Sits between the CPU sequencer and the 4-bit ALU datapath and enables 16-bit and wider shift/BCD operations without widening the ALU.

Parameters:
ALU_WIDTH, 4, bits per digit (ALU slice width)
DIGITS, 2, digits per word; WORD_SIZE = ALU_WIDTH*DIGITS; DIGITS >= 2

Ports:
clk  in  1  system clock, all state on rising edge
nreset  in  1  asynchronous active-low reset
start  in  1  launch operation; sampled only when busy=0
op  in  2  0 SHIFT, 1 DAA, 2 COND, 3 SWAP (see Optional Feature)
op543  in  3  shift mode / condition select (opcode bits [5:3])
sub  in  1  N flag; DAA subtract mode
carry_in  in  1  C flag
half_in  in  1  H flag
zero_in  in  1  Z flag
data_in  in  WORD_SIZE  operand, captured on accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse; result outputs valid on and after it
data_out  out  WORD_SIZE  result, held until the next done
carry_out  out  1  resulting C
zero_out  out  1  1 when data_out==0 (SHIFT/DAA/SWAP); zero_in for COND
half_out  out  1  always 0 after SHIFT/DAA/SWAP; half_in for COND
cond_result  out  1  buffered condition, updated only by COND

Behaviour:
- Reset: state IDLE, busy=0, done=0, data_out=0, carry_out=0, zero_out=0, half_out=0, cond_result=0, digit index=0. Reset asserted mid-operation aborts it, with no done pulse.
- FSM: IDLE -> (start) RUN -> DONE -> IDLE. COND and unsupported ops go IDLE -> DONE directly.
- RUN lasts exactly DIGITS cycles, one digit per cycle. start->done latency is DIGITS+1 cycles for SHIFT/DAA/SWAP and 1 cycle for COND.
- start while busy=1 or in DONE is ignored; no queueing. start in the cycle after done is accepted.
- Operands and flags are latched at accept; later input changes have no effect.
- SHIFT, left modes (op543[0]=0): LSB digit first; each digit's shifted-out MSB is the carry into the next digit.
- SHIFT, right modes (op543[0]=1): MSB digit first.
- SHIFT carry-in to the first digit: RLC(0)/SRA(5)=word MSB; RRC(1)=word LSB; RL(2)/RR(3)=carry_in; SLA(4)/SRL(7)=0; SLL(6)=1.
- SHIFT carry_out = last bit shifted out of the word.
- DAA add (sub=0): LSB first. c_0=0. For each digit d_i, v=d_i+c_i; correct (+6, mod 2^ALU_WIDTH) if v>9 or f_i. f_0=half_in, f_top=carry_in, all other f_i=0. c_{i+1} = (v>9).
- DAA add: carry_out = 1 if the top digit is corrected, else 0. For DIGITS=2 this equals SM83 DAA exactly.
- DAA subtract (sub=1): digit 0 -6 if half_in; top digit -6 if carry_in; middle digits unchanged; no inter-digit borrow; carry_out = carry_in.
- COND: cond_result <= op543[1:0]: 0 !zero_in, 1 zero_in, 2 !carry_in, 3 carry_in. data_out and carry_out are unchanged.
- All widths are modulo; no saturation.

Optional Feature:
SM83_ALU_SEQ_SWAP_EN:
- Defined: op=3 rotates the word right by ALU_WIDTH, one digit per cycle (0x12 -> 0x21 for DIGITS=2). carry_out=0.
- Undefined: op=3 is a NOP: done after 1 cycle, data_out=data_in, zero_out=(data_in==0), carry_out=carry_in.

Decomposition:
- Package sm83_alu_pkg: ALU_WIDTH constant, hword_t, alu_seq_op_t enum (SHIFT, DAA, COND, SWAP), shift-mode enum for op543, BCD constants 9 and 6.
- One combinational sub-module sm83_alu_digit: one digit step (shift or DAA correct), carry in/out. The sequencer owns the FSM, digit index, operand/result registers and flags.

Test Plan:
- DIGITS=2, SHIFT op543=0, data 0x85 -> done on cycle 3; data_out=0x0B, carry_out=1, zero_out=0.
- SHIFT op543=3, data 0x01, carry_in=1 -> data_out=0x80, carry_out=1; op543=7, data 0x01 -> 0x00, carry_out=1, zero_out=1.
- DAA sub=0: 0x9A H=0 C=0 -> 0x00 C=1 Z=1; 0x10 H=1 -> 0x16 C=0. DIGITS=4: 0x999A -> 0x0000 C=1.
- DAA sub=1: 0x0F H=1 C=1 -> 0xA9 C=1; COND op543=3 carry_in=1 -> cond_result=1 one cycle after start, data_out unchanged.
- start held high through busy -> exactly one done per DIGITS+2 cycles; second operand taken only after done.
- nreset low in RUN cycle 1 -> busy=0, data_out=0, no done. With and without SWAP_EN: op=3 on 0x12 -> 0x21 after 3 cycles vs 0x12 after 1 cycle.
